ricevitore_dav_rfd: RTL and testbench

- Consumer end of the team's 8-bit dav_/rfd four-phase handshake, i.e. the receiver for a producer that drives dav_ low with valid data.
- Each accepted byte is captured into a small synchronous FIFO.
- A local reader drains the FIFO with a show-ahead rd/empty interface.
- Sits between a minimum-of-three acquisition unit and downstream processing, decoupling the producer from reader stalls.

---
 rtl/ricevitore_dav_rfd_pkg.sv | 14 +
 rtl/ricevitore_dav_rfd_fifo_sync.sv | 63 ++++++
 rtl/ricevitore_dav_rfd.sv | 87 ++++++++
 tb/tb_ricevitore_dav_rfd.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ricevitore_dav_rfd_pkg.sv
// Shared types and constants for the dav_/rfd byte receiver.
package ricevitore_pkg;

    typedef enum logic {
        WAIT_DAV = 1'b0,
        WAIT_END = 1'b1
    } state_t;

    localparam int unsigned DATA_W = 8;

    // Reset value of the running minimum (the largest byte, so any write lowers it)
    localparam logic [DATA_W-1:0] MIN_INIT = 8'hFF;

endpackage

// File: rtl/ricevitore_dav_rfd_fifo_sync.sv
// Synchronous show-ahead FIFO: registered occupancy count, power-of-two depth,
// and pointers that wrap naturally modulo DEPTH.
module fifo_sync #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Flags come straight from the registered count, so there is no write bypass when full
    assign empty = (count == CW'(0));
    assign full  = (count == CW'(DEPTH));
    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;

    // Head is forced to zero while empty so dout never shows stale data
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage array; needs no reset because empty masks the head
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ricevitore_dav_rfd.sv
// Consumer side of the 8-bit dav_/rfd four-phase handshake, buffering accepted
// bytes in a small FIFO drained by a local show-ahead reader.
// Optional build macro RICEVITORE_MIN_TRACK_EN adds the min_seen output,
// the running unsigned minimum of every byte written into the FIFO.
module ricevitore_dav_rfd
    import ricevitore_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              dav_,
    input  logic [DATA_W-1:0] data,
    output logic              rfd,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
`ifdef RICEVITORE_MIN_TRACK_EN
    ,
    output logic [DATA_W-1:0] min_seen
`endif
);

    state_t state;
    logic   wr_en;

    // A byte is taken only on the first dav_ low sample with room in the FIFO
    assign wr_en = (state == WAIT_DAV) & ~dav_ & ~full;

    // Handshake FSM; rfd is registered and falls on the capture edge
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= WAIT_DAV;
            rfd   <= 1'b1;
        end else begin
            case (state)
                WAIT_DAV: begin
                    if (wr_en) begin
                        state <= WAIT_END;
                        rfd   <= 1'b0;
                    end
                end
                WAIT_END: begin
                    if (dav_) begin
                        state <= WAIT_DAV;
                        rfd   <= 1'b1;
                    end
                end
                default: begin
                    state <= WAIT_DAV;
                    rfd   <= 1'b1;
                end
            endcase
        end
    end

    // Byte buffer between the producer and the local reader
    fifo_sync #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock  (clock),
        .reset_ (reset_),
        .wr     (wr_en),
        .wdata  (data),
        .rd     (rd),
        .rdata  (dout),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

`ifdef RICEVITORE_MIN_TRACK_EN
    // Running unsigned minimum of written bytes; reads leave it alone
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            min_seen <= MIN_INIT;
        end else if (wr_en && (data < min_seen)) begin
            min_seen <= data;
        end
    end
`endif

endmodule

// File: tb/tb_ricevitore_dav_rfd.sv
// Directed, table-driven bench for ricevitore_dav_rfd (DEPTH=4).
module tb_ricevitore_dav_rfd;

    logic       clock = 1'b0;
    logic       reset_;
    logic       dav_;
    logic [7:0] data;
    logic       rd;
    logic       rfd;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [2:0] count;
`ifdef RICEVITORE_MIN_TRACK_EN
    logic [7:0] min_seen;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       dav_n;
        logic [7:0] din;
        logic       rd;
        logic       rfd;
        logic       empty;
        logic       full;
        logic [2:0] count;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];

    ricevitore_dav_rfd #(.DEPTH(4)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .dav_     (dav_),
        .data     (data),
        .rfd      (rfd),
        .rd       (rd),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count)
`ifdef RICEVITORE_MIN_TRACK_EN
        ,
        .min_seen (min_seen)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic dn, input logic [7:0] d, input logic r, input logic f,
                       input logic e, input logic fu, input logic [2:0] c, input logic [7:0] o);
        vec_t v;
        v.dav_n = dn; v.din = d; v.rd = r; v.rfd = f;
        v.empty = e; v.full = fu; v.count = c; v.dout = o;
        vecs.push_back(v);
    endtask

    initial begin
        // dav_, data, rd  ->  rfd, empty, full, count, dout (after the edge)
        // single transfer of 3C, then drain it
        add(0, 8'h3C, 0, 0, 0, 0, 3'd1, 8'h3C);
        add(0, 8'h3C, 0, 0, 0, 0, 3'd1, 8'h3C);
        add(1, 8'h3C, 0, 1, 0, 0, 3'd1, 8'h3C);
        add(1, 8'h00, 1, 1, 1, 0, 3'd0, 8'h00);
        // fill with 01..04
        add(0, 8'h01, 0, 0, 0, 0, 3'd1, 8'h01);
        add(1, 8'h01, 0, 1, 0, 0, 3'd1, 8'h01);
        add(0, 8'h02, 0, 0, 0, 0, 3'd2, 8'h01);
        add(1, 8'h02, 0, 1, 0, 0, 3'd2, 8'h01);
        add(0, 8'h03, 0, 0, 0, 0, 3'd3, 8'h01);
        add(1, 8'h03, 0, 1, 0, 0, 3'd3, 8'h01);
        add(0, 8'h04, 0, 0, 0, 1, 3'd4, 8'h01);
        add(1, 8'h04, 0, 1, 0, 1, 3'd4, 8'h01);
        // 05 offered while full: stalls with rfd high
        add(0, 8'h05, 0, 1, 0, 1, 3'd4, 8'h01);
        add(0, 8'h05, 0, 1, 0, 1, 3'd4, 8'h01);
        // one pop: full blocks the write on this edge, 05 lands on the next
        add(0, 8'h05, 1, 1, 0, 0, 3'd3, 8'h02);
        add(0, 8'h05, 0, 0, 0, 1, 3'd4, 8'h02);
        add(1, 8'h05, 0, 1, 0, 1, 3'd4, 8'h02);
        // drain in order, then extra rd on empty
        add(1, 8'h00, 1, 1, 0, 0, 3'd3, 8'h03);
        add(1, 8'h00, 1, 1, 0, 0, 3'd2, 8'h04);
        add(1, 8'h00, 1, 1, 0, 0, 3'd1, 8'h05);
        add(1, 8'h00, 1, 1, 1, 0, 3'd0, 8'h00);
        add(1, 8'h00, 1, 1, 1, 0, 3'd0, 8'h00);
        add(1, 8'h00, 1, 1, 1, 0, 3'd0, 8'h00);
        add(1, 8'h00, 1, 1, 1, 0, 3'd0, 8'h00);
        // pointers still aligned after underflow attempts
        add(0, 8'h77, 0, 0, 0, 0, 3'd1, 8'h77);
        add(1, 8'h77, 0, 1, 0, 0, 3'd1, 8'h77);
        // count=2, then write AA on the same edge as a pop
        add(0, 8'h11, 0, 0, 0, 0, 3'd2, 8'h77);
        add(1, 8'h11, 0, 1, 0, 0, 3'd2, 8'h77);
        add(0, 8'hAA, 1, 0, 0, 0, 3'd2, 8'h11);
        add(1, 8'hAA, 1, 1, 0, 0, 3'd1, 8'hAA);
        add(1, 8'hAA, 1, 1, 1, 0, 3'd0, 8'h00);

        reset_ = 1'b0;
        dav_   = 1'b1;
        data   = 8'h00;
        rd     = 1'b0;
        #12;
        chk("reset rfd",   32'(rfd),   32'(1));
        chk("reset empty", 32'(empty), 32'(1));
        chk("reset full",  32'(full),  32'(0));
        chk("reset count", 32'(count), 32'(0));
        chk("reset dout",  32'(dout),  32'(0));
`ifdef RICEVITORE_MIN_TRACK_EN
        chk("reset min", 32'(min_seen), 32'hFF);
`endif
        @(negedge clock);
        reset_ = 1'b1;

        foreach (vecs[i]) begin
            dav_ = vecs[i].dav_n;
            data = vecs[i].din;
            rd   = vecs[i].rd;
            step();
            chk($sformatf("v%0d rfd", i),   32'(rfd),   32'(vecs[i].rfd));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d full", i),  32'(full),  32'(vecs[i].full));
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].count));
            if (!vecs[i].empty) begin
                chk($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].dout));
            end
        end

        // reset while in WAIT_END with 3 entries, dav_ held low across release
        rd = 1'b0;
        dav_ = 1'b0; data = 8'hA1; step();
        dav_ = 1'b1; step();
        dav_ = 1'b0; data = 8'hA2; step();
        dav_ = 1'b1; step();
        dav_ = 1'b0; data = 8'hA3; step();
        chk("pre-rst count", 32'(count), 32'(3));
        chk("pre-rst rfd",   32'(rfd),   32'(0));
        reset_ = 1'b0;
        #1;
        chk("async rst rfd",   32'(rfd),   32'(1));
        chk("async rst count", 32'(count), 32'(0));
        chk("async rst empty", 32'(empty), 32'(1));
        chk("async rst dout",  32'(dout),  32'(0));
        @(negedge clock);
        reset_ = 1'b1;
        step();
        chk("recapture count", 32'(count), 32'(1));
        chk("recapture dout",  32'(dout),  32'hA3);
        chk("recapture rfd",   32'(rfd),   32'(0));
        dav_ = 1'b1;
        step();
        chk("recapture end rfd", 32'(rfd), 32'(1));

`ifdef RICEVITORE_MIN_TRACK_EN
        // running minimum; rd kept high so reads occur and must not disturb it
        @(negedge clock); reset_ = 1'b0;
        @(negedge clock); reset_ = 1'b1;
        chk("min after rst", 32'(min_seen), 32'hFF);
        rd = 1'b1;
        dav_ = 1'b0; data = 8'h50; step();
        chk("min 50", 32'(min_seen), 32'h50);
        dav_ = 1'b1; step();
        dav_ = 1'b0; data = 8'h20; step();
        chk("min 20", 32'(min_seen), 32'h20);
        dav_ = 1'b1; step();
        dav_ = 1'b0; data = 8'h90; step();
        chk("min stays 20", 32'(min_seen), 32'h20);
        dav_ = 1'b1; step();
        rd = 1'b0;
        reset_ = 1'b0;
        #1;
        chk("min reset FF", 32'(min_seen), 32'hFF);
        @(negedge clock); reset_ = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
